// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte FIFO feeding a UART transmitter handshake
//
// Purpose: buffers bytes from the bus-side writer in a circular FIFO and
// starts them one at a time on the transmitter via tx_en/tx_data, waiting
// for tx_ack before the next character.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_data      enqueue strobe and byte
//   flush               discard queued bytes not yet started
//   send_en             allow new characters to start
//   clr_ovf             clear sticky overflow flag
//   full, empty, level  FIFO occupancy status
//   overflow            sticky: a write was dropped while full
//   idle                FIFO empty, FSM idle and transmitter not busy
//   tx_en, tx_data      start pulse and byte to transmitter
//   tx_busy, tx_ack     transmitter busy flag and character-done pulse

module uart_tx_fifo #(
    parameter int DEPTH_WIDTH = 4,
    parameter int DATA_BITS   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic                   flush,
    input  logic                   send_en,
    input  logic                   clr_ovf,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_WIDTH:0]   level,
    output logic                   overflow,
    output logic                   idle,
    output logic                   tx_en,
    output logic [DATA_BITS-1:0]   tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_ack
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0]   LEVEL_FULL = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   LEVEL_ONE  = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE    = DEPTH_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t                 state_q;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr_q;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q;
    logic [DEPTH_WIDTH:0]   level_q;
    logic [DEPTH_WIDTH:0]   level_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic                   tx_en_q;
    logic [DATA_BITS-1:0]   tx_data_q;

    logic push;
    logic pop;
    logic drop;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);

    // A flush suppresses both the write and the pop in its cycle; a write
    // lost to a flush is not an overflow.
    assign push = wr_en & ~full & ~flush;
    assign drop = wr_en &  full & ~flush;
    assign pop  = (state_q == S_IDLE) & send_en & ~empty & ~tx_busy & ~flush;

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_ONE;
        end
    end

    // Setting wins over clearing in the same cycle.
    assign ovf_d = drop | (ovf_q & ~clr_ovf);

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tx_data_q <= mem_q[rd_ptr_q];
                        tx_en_q   <= 1'b1;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    tx_en_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A flush here does not abort the character in flight.
                    if (tx_ack) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_en_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign level    = level_q;
    assign overflow = ovf_q;
    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign idle     = empty & (state_q == S_IDLE) & ~tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       send_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       idle;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       tx_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int ack_delay = 100;

    uart_tx_fifo #(.DEPTH_WIDTH(4), .DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .flush(flush), .send_en(send_en), .clr_ovf(clr_ovf),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .idle(idle), .tx_en(tx_en), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_ack(tx_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: busy rises at the edge after the tx_en cycle,
    // ack pulses after ack_delay busy cycles, busy drops with the ack's end.
    initial begin
        bit pend;
        int cnt;
        pend = 0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_ack) begin
                tx_ack  = 1'b0;
                tx_busy = 1'b0;
            end else if (tx_busy) begin
                cnt++;
                if (cnt >= ack_delay) tx_ack = 1'b1;
            end
            if (pend) begin
                tx_busy = 1'b1;
                cnt = 0;
                pend = 0;
            end
            if (tx_en) pend = 1;
        end
    end

    // Behavioural model: queue of bytes, a "character in flight" flag and the
    // list of bytes expected on the transmitter in order.
    byte unsigned mq[$];
    byte unsigned sent[$];
    bit           m_ovf, m_active, m_just, m_en;
    byte unsigned m_data;

    initial begin
        bit pop_m, full_m, set_m;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_ovf = 0; m_active = 0; m_just = 0; m_en = 0; m_data = 0;
            end else begin
                full_m = (mq.size() == DEPTH);
                pop_m  = !m_active && send_en && mq.size() != 0 && !tx_busy && !flush;
                set_m  = 0;
                if (m_active && !m_just && tx_ack) m_active = 0;
                m_just = pop_m;
                m_en   = pop_m;
                if (pop_m) begin
                    m_data = mq.pop_front();
                    sent.push_back(m_data);
                    m_active = 1;
                end
                if (flush) mq.delete();
                else if (wr_en) begin
                    if (full_m) set_m = 1;
                    else mq.push_back(wr_data);
                end
                m_ovf = set_m | (m_ovf & !clr_ovf);
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rst_n) begin
                check("level", 32'(level), 32'(mq.size()));
                check("full", 32'(full), 32'(mq.size() == DEPTH));
                check("empty", 32'(empty), 32'(mq.size() == 0));
                check("overflow", 32'(overflow), 32'(m_ovf));
                check("tx_en", 32'(tx_en), 32'(m_en));
                check("tx_data", 32'(tx_data), 32'(m_data));
                check("idle", 32'(idle), 32'(mq.size() == 0 && !m_active && !tx_busy));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        int base;
        // Reset state
        cyc(3);
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_tx_en", 32'(tx_en), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);

        // Single byte, long transmitter
        send_en = 1'b1;
        write(8'hA5);
        cyc(110);
        check("single_count", 32'(sent.size()), 1);
        check("single_byte", 32'(sent[0]), 32'hA5);
        check("single_idle", 32'(idle), 1);

        // Burst of 17 while paused
        ack_delay = 6;
        send_en = 1'b0;
        for (int i = 0; i < 17; i++) write(8'(i));
        check("burst_level", 32'(level), 16);
        check("burst_full", 32'(full), 1);
        check("burst_ovf", 32'(overflow), 1);
        base = sent.size();
        send_en = 1'b1;
        cyc(16 * 12);
        check("burst_count", 32'(sent.size() - base), 16);
        for (int i = 0; i < 16; i++) check("burst_order", 32'(sent[base + i]), 32'(i));
        check("burst_empty", 32'(empty), 1);

        // Clear overflow, refill, then write while the FSM pops at full
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 0);
        send_en = 1'b0;
        for (int i = 0; i < 16; i++) write(8'(8'h40 + i));
        send_en = 1'b1;
        write(8'hEE);
        check("popfull_level", 32'(level), 15);
        check("popfull_ovf", 32'(overflow), 1);
        cyc(16 * 12);
        check("popfull_last", 32'(sent[sent.size() - 1]), 32'h4F);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;

        // Flush while 0x11 is in flight
        base = sent.size();
        write(8'h11);
        write(8'h22);
        write(8'h33);
        cyc(2);
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h44;
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        check("flush_level", 32'(level), 0);
        check("flush_ovf", 32'(overflow), 0);
        cyc(20);
        check("flush_count", 32'(sent.size() - base), 1);
        check("flush_byte", 32'(sent[base]), 32'h11);

        // Pause mid-character
        base = sent.size();
        write(8'h55);
        write(8'h66);
        send_en = 1'b0;
        cyc(20);
        check("pause_count", 32'(sent.size() - base), 1);
        check("pause_level", 32'(level), 1);
        send_en = 1'b1;
        cyc(20);
        check("resume_count", 32'(sent.size() - base), 2);
        check("resume_byte", 32'(sent[base + 1]), 32'h66);

        // Asynchronous reset mid-run with bytes queued
        send_en = 1'b0;
        write(8'h77);
        write(8'h88);
        base = sent.size();
        rst_n = 1'b0;
        #1;
        check("arst_level", 32'(level), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_tx_data", 32'(tx_data), 0);
        check("arst_idle", 32'(idle), 1);
        @(negedge clk);
        rst_n = 1'b1;
        send_en = 1'b1;
        cyc(6);
        check("arst_nostart", 32'(sent.size() - base), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
